// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
//
// Purpose:
//   Parallel-to-serial transmitter for the audio codec DAC path. Stereo sample
//   pairs arrive from the last filter stage over a valid/ready handshake and
//   wait in a small FIFO. Each pair is shifted out MSB-first on AUD_DACDAT.
//   AUD_DACLRCK comes from the codec and frames the output: a rising LRCK edge
//   starts a new frame with the left channel, and the following falling edge
//   switches to the right channel.
//
// Parameters:
//   SAMPLE_WIDTH  bits per channel sample (default 32)
//   FIFO_DEPTH    stereo pairs buffered; a power of two, at least 2 (default 4)
//
// Ports:
//   AUD_BCLK                codec bit clock; all logic runs on its rising edge
//   reset                   synchronous, active-high reset
//   left_channel_audio_in   left sample, two's complement
//   right_channel_audio_in  right sample, two's complement
//   sample_valid            a stereo pair is presented
//   sample_ready            the FIFO can accept a pair (combinational, !full)
//   AUD_DACLRCK             codec frame clock; high = left, low = right
//   AUD_DACDAT              serial DAC data, registered
//   underrun                one-cycle pulse when a frame starts with no data
//   underrun_count          saturating count of underruns
//
// Build option:
//   I2S_DELAY_EN  when defined, every channel starts with one zero bit before
//                 the MSB (I2S framing). When undefined, the MSB follows the
//                 LRCK edge directly (left-justified framing).
// -----------------------------------------------------------------------------
module audio_dac_serializer #(
    parameter int SAMPLE_WIDTH = 32,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    AUD_BCLK,
    input  logic                    reset,
    input  logic [SAMPLE_WIDTH-1:0] left_channel_audio_in,
    input  logic [SAMPLE_WIDTH-1:0] right_channel_audio_in,
    input  logic                    sample_valid,
    output logic                    sample_ready,
    input  logic                    AUD_DACLRCK,
    output logic                    AUD_DACDAT,
    output logic                    underrun,
    output logic [15:0]             underrun_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int BIT_W = $clog2(SAMPLE_WIDTH + 1);

`ifdef I2S_DELAY_EN
    localparam logic [BIT_W-1:0] LOAD_BITS = BIT_W'(SAMPLE_WIDTH);
`else
    localparam logic [BIT_W-1:0] LOAD_BITS = BIT_W'(SAMPLE_WIDTH - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } state_t;

    logic [SAMPLE_WIDTH-1:0] fifoLeft_q  [FIFO_DEPTH];
    logic [SAMPLE_WIDTH-1:0] fifoRight_q [FIFO_DEPTH];

    logic [PTR_W-1:0]        wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]        rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]        occupancy_q, occupancy_d;

    state_t                  state_q, state_d;
    logic                    lrckPrev_q, lrckPrev_d;
    logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
    logic [SAMPLE_WIDTH-1:0] rightHold_q, rightHold_d;
    logic [BIT_W-1:0]        bitCnt_q, bitCnt_d;
    logic                    dacDat_q, dacDat_d;
    logic                    underrun_q, underrun_d;
    logic [15:0]             underrunCount_q, underrunCount_d;

    logic                    lrckRise;
    logic                    lrckFall;
    logic                    fifoEmpty;
    logic                    fifoFull;
    logic                    pushEn;
    logic                    popEn;
    logic                    loadEn;
    logic [SAMPLE_WIDTH-1:0] loadWord;

    // Handshake and framing events. LRCK edges are found by comparing the
    // current LRCK level with the level seen at the previous clock edge.
    // A pair offered while the FIFO is full is refused even if a pop happens
    // in the same cycle: ready only looks at the current occupancy, so the
    // upstream stage never has to guess whether a pop is about to happen.
    always_comb begin
        lrckRise  = AUD_DACLRCK & ~lrckPrev_q;
        lrckFall  = ~AUD_DACLRCK & lrckPrev_q;
        fifoEmpty = (occupancy_q == '0);
        fifoFull  = (occupancy_q == CNT_W'(FIFO_DEPTH));
        pushEn    = sample_valid & ~fifoFull;
        popEn     = lrckRise & ~fifoEmpty;
    end

    // FIFO bookkeeping. The pointers are exactly log2(depth) bits wide, so
    // they wrap around the storage without any explicit compare. Pushing and
    // popping in the same cycle leaves the occupancy unchanged.
    always_comb begin
        wrPtr_d     = wrPtr_q;
        rdPtr_d     = rdPtr_q;
        occupancy_d = occupancy_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushEn, popEn})
            2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
            2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
            default: occupancy_d = occupancy_q;
        endcase
    end

    // Frame sequencing and the serial shifter.
    // A rising LRCK edge always starts a new left channel, whatever the
    // current state, so a short frame from the codec resynchronises us
    // immediately. If the FIFO is empty at that moment the frame is sent as
    // silence and counted as an underrun. The right sample of the popped
    // pair is parked in rightHold until the falling edge asks for it; a
    // falling edge outside the left channel (for example straight after
    // reset) carries no data and is ignored.
    // Any load discards whatever bits of the previous channel were not yet
    // sent. Once the bit counter reaches zero the line is held low until the
    // next load. In the left-justified build the MSB goes straight to the
    // output register during the load; in the I2S build the output stays low
    // for that cycle and all SAMPLE_WIDTH bits leave one cycle later.
    always_comb begin
        state_d         = state_q;
        lrckPrev_d      = AUD_DACLRCK;
        shift_d         = shift_q;
        rightHold_d     = rightHold_q;
        bitCnt_d        = bitCnt_q;
        dacDat_d        = 1'b0;
        underrun_d      = 1'b0;
        underrunCount_d = underrunCount_q;
        loadEn          = 1'b0;
        loadWord        = '0;

        if (lrckRise) begin
            state_d = LEFT;
            loadEn  = 1'b1;
            if (!fifoEmpty) begin
                loadWord    = fifoLeft_q[rdPtr_q];
                rightHold_d = fifoRight_q[rdPtr_q];
            end else begin
                loadWord    = '0;
                rightHold_d = '0;
                underrun_d  = 1'b1;
                if (underrunCount_q != 16'hFFFF) begin
                    underrunCount_d = underrunCount_q + 16'd1;
                end
            end
        end else if (lrckFall && (state_q == LEFT)) begin
            state_d  = RIGHT;
            loadEn   = 1'b1;
            loadWord = rightHold_q;
        end

        if (loadEn) begin
            bitCnt_d = LOAD_BITS;
`ifdef I2S_DELAY_EN
            shift_d  = loadWord;
            dacDat_d = 1'b0;
`else
            shift_d  = {loadWord[SAMPLE_WIDTH-2:0], 1'b0};
            dacDat_d = loadWord[SAMPLE_WIDTH-1];
`endif
        end else if (bitCnt_q != '0) begin
            dacDat_d = shift_q[SAMPLE_WIDTH-1];
            shift_d  = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
            bitCnt_d = bitCnt_q - BIT_W'(1);
        end
    end

    // Sample storage. The data words are not reset: the pointers and the
    // occupancy count decide what is valid, so stale contents are never read.
    always_ff @(posedge AUD_BCLK) begin
        if (pushEn) begin
            fifoLeft_q[wrPtr_q]  <= left_channel_audio_in;
            fifoRight_q[wrPtr_q] <= right_channel_audio_in;
        end
    end

    // Every control and output register. Reset abandons any frame in flight,
    // empties the FIFO and forgets the last LRCK level, so an LRCK that is
    // already high when reset is released counts as a rising edge.
    always_ff @(posedge AUD_BCLK) begin
        if (reset) begin
            state_q         <= IDLE;
            lrckPrev_q      <= 1'b0;
            wrPtr_q         <= '0;
            rdPtr_q         <= '0;
            occupancy_q     <= '0;
            shift_q         <= '0;
            rightHold_q     <= '0;
            bitCnt_q        <= '0;
            dacDat_q        <= 1'b0;
            underrun_q      <= 1'b0;
            underrunCount_q <= 16'd0;
        end else begin
            state_q         <= state_d;
            lrckPrev_q      <= lrckPrev_d;
            wrPtr_q         <= wrPtr_d;
            rdPtr_q         <= rdPtr_d;
            occupancy_q     <= occupancy_d;
            shift_q         <= shift_d;
            rightHold_q     <= rightHold_d;
            bitCnt_q        <= bitCnt_d;
            dacDat_q        <= dacDat_d;
            underrun_q      <= underrun_d;
            underrunCount_q <= underrunCount_d;
        end
    end

    // The outputs come straight from registers, except ready, which has to
    // follow the occupancy in the same cycle.
    always_comb begin
        sample_ready   = ~fifoFull;
        AUD_DACDAT     = dacDat_q;
        underrun       = underrun_q;
        underrun_count = underrunCount_q;
    end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_serializer
//
// Self-checking bench for audio_dac_serializer with the default parameters.
// A queue-based model predicts the serial stream from the framing rules:
// each load turns a sample into a list of bits, and the list is drained one
// bit per clock. The compare process checks the DUT against this model on
// every falling edge. The directed sequence also checks a few hand-computed
// literals: captured words, the MSB position and the underrun counts.
// Compile with I2S_DELAY_EN defined to check the I2S build.
// -----------------------------------------------------------------------------
module tb_audio_dac_serializer;

    localparam int FIFO_DEPTH = 4;
`ifdef I2S_DELAY_EN
    localparam int OFF = 1;
`else
    localparam int OFF = 0;
`endif

    logic        AUD_BCLK;
    logic        reset;
    logic [31:0] left_channel_audio_in;
    logic [31:0] right_channel_audio_in;
    logic        sample_valid;
    logic        sample_ready;
    logic        AUD_DACLRCK;
    logic        AUD_DACDAT;
    logic        underrun;
    logic [15:0] underrun_count;

    int checkCount = 0;
    int passCount  = 0;
    int lastFirstOne;

    audio_dac_serializer #(
        .SAMPLE_WIDTH(32),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .AUD_BCLK(AUD_BCLK),
        .reset(reset),
        .left_channel_audio_in(left_channel_audio_in),
        .right_channel_audio_in(right_channel_audio_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .AUD_DACLRCK(AUD_DACLRCK),
        .AUD_DACDAT(AUD_DACDAT),
        .underrun(underrun),
        .underrun_count(underrun_count)
    );

    // Bit clock with a 10-unit period.
    initial begin
        AUD_BCLK = 1'b0;
        forever #5 AUD_BCLK = ~AUD_BCLK;
    end

    // Compares one value and updates the counters.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end else begin
            passCount++;
        end
    endtask

    // Behavioural model: a FIFO of 64-bit pairs, plus a list of bits still
    // waiting to go out on the data line.
    logic [63:0] mQ[$];
    bit          mBits[$];
    int          mState;
    logic        mPrev;
    logic [31:0] mRightHold;
    logic        mDat;
    logic        mUnder;
    logic [15:0] mCount;
    bit          modelValid = 0;
    bit          mRise, mFall, mAccept;
    logic [63:0] mPair;
    logic [63:0] mFront;

    // Starts a new channel: queue its bits MSB-first, plus one leading zero
    // in the I2S build, then present the first bit.
    function automatic void modelLoad(input logic [31:0] s);
        mBits.delete();
        if (OFF == 1) mBits.push_back(1'b0);
        for (int i = 31; i >= 0; i--) mBits.push_back(s[i]);
        mDat = mBits.pop_front();
    endfunction

    // Advances the model by one clock, using the same inputs the DUT sees
    // at this rising edge.
    always @(posedge AUD_BCLK) begin
        if (reset) begin
            mQ.delete();
            mBits.delete();
            mState     = 0;
            mPrev      = 1'b0;
            mRightHold = '0;
            mDat       = 1'b0;
            mUnder     = 1'b0;
            mCount     = 16'd0;
            modelValid = 1;
        end else begin
            mRise   = AUD_DACLRCK && !mPrev;
            mFall   = !AUD_DACLRCK && mPrev;
            mAccept = sample_valid && (mQ.size() < FIFO_DEPTH);
            mPair   = {left_channel_audio_in, right_channel_audio_in};
            mUnder  = 1'b0;
            if (mRise) begin
                if (mQ.size() > 0) begin
                    mFront     = mQ.pop_front();
                    mRightHold = mFront[31:0];
                    modelLoad(mFront[63:32]);
                end else begin
                    mRightHold = '0;
                    mUnder     = 1'b1;
                    if (mCount != 16'hFFFF) mCount = mCount + 16'd1;
                    modelLoad(32'd0);
                end
                mState = 1;
            end else if (mFall && mState == 1) begin
                modelLoad(mRightHold);
                mState = 2;
            end else begin
                mDat = (mBits.size() > 0) ? mBits.pop_front() : 1'b0;
            end
            if (mAccept) mQ.push_back(mPair);
            mPrev = AUD_DACLRCK;
        end
    end

    // Compare process: on every falling edge once the model has seen reset.
    always @(negedge AUD_BCLK) begin
        if (modelValid) begin
            checkOutput("dacdat", {31'd0, AUD_DACDAT}, {31'd0, mDat});
            checkOutput("underrun", {31'd0, underrun}, {31'd0, mUnder});
            checkOutput("underrun_count", {16'd0, underrun_count}, {16'd0, mCount});
            checkOutput("sample_ready", {31'd0, sample_ready},
                        {31'd0, (mQ.size() < FIFO_DEPTH)});
        end
    end

    // Offers one pair for a single clock while LRCK is held steady.
    task automatic applyStimulus(input logic [31:0] l, input logic [31:0] r);
        left_channel_audio_in  = l;
        right_channel_audio_in = r;
        sample_valid           = 1'b1;
        @(negedge AUD_BCLK);
        sample_valid = 1'b0;
    endtask

    // Runs one LRCK frame with the given half-frame length and captures the
    // bits that fit into each half, right-aligned. pushAtRise also offers a
    // pair in the cycle where the rising edge is sampled.
    task automatic runFrame(input int halfLen, input bit pushAtRise,
                            input logic [31:0] pl, input logic [31:0] pr,
                            output logic [31:0] capL, output logic [31:0] capR);
        int n;
        n = halfLen - OFF;
        if (n > 32) n = 32;
        capL = '0;
        capR = '0;
        lastFirstOne = -1;
        AUD_DACLRCK = 1'b1;
        if (pushAtRise) begin
            left_channel_audio_in  = pl;
            right_channel_audio_in = pr;
            sample_valid           = 1'b1;
        end
        for (int i = 0; i < halfLen; i++) begin
            @(negedge AUD_BCLK);
            sample_valid = 1'b0;
            if (AUD_DACDAT === 1'b1 && lastFirstOne < 0) lastFirstOne = i;
            if (i >= OFF && i < OFF + n) capL = {capL[30:0], AUD_DACDAT};
        end
        AUD_DACLRCK = 1'b0;
        for (int i = 0; i < halfLen; i++) begin
            @(negedge AUD_BCLK);
            if (i >= OFF && i < OFF + n) capR = {capR[30:0], AUD_DACDAT};
        end
    endtask

    function automatic logic [31:0] topBits(input logic [31:0] w, input int n);
        return w >> (32 - n);
    endfunction

    logic [31:0] fullL [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    logic [31:0] fullR [4] = '{32'h91111111, 32'hA2222222, 32'hB3333333, 32'hC4444444};

    // Directed sequence.
    initial begin
        logic [31:0] cl, cr;
        int nFull;
        nFull = 32 - OFF;
        AUD_DACLRCK            = 1'b0;
        reset                  = 1'b1;
        sample_valid           = 1'b0;
        left_channel_audio_in  = '0;
        right_channel_audio_in = '0;

        repeat (3) @(negedge AUD_BCLK);
        checkOutput("reset_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
        checkOutput("reset_ready", {31'd0, sample_ready}, 32'd1);
        checkOutput("reset_underrun", {31'd0, underrun}, 32'd0);
        checkOutput("reset_count", {16'd0, underrun_count}, 32'd0);
        reset = 1'b0;

        // A basic frame with one pair queued before the first rising edge.
        applyStimulus(32'hA5000001, 32'h80000000);
        runFrame(32, 1'b0, '0, '0, cl, cr);
`ifdef I2S_DELAY_EN
        checkOutput("basic_left", cl, 32'h52800000);
        checkOutput("basic_right", cr, 32'h40000000);
        checkOutput("basic_msb_offset", lastFirstOne, 32'd1);
`else
        checkOutput("basic_left", cl, 32'hA5000001);
        checkOutput("basic_right", cr, 32'h80000000);
        checkOutput("basic_msb_offset", lastFirstOne, 32'd0);
`endif
        checkOutput("basic_no_underrun", {16'd0, underrun_count}, 32'd0);

        // Three frames with nothing queued, then a single pair.
        for (int f = 0; f < 3; f++) runFrame(32, 1'b0, '0, '0, cl, cr);
        checkOutput("underrun_count_3", {16'd0, underrun_count}, 32'd3);
        checkOutput("underrun_left_zero", cl, 32'd0);
        applyStimulus(32'h12345678, 32'h9ABCDEF0);
        runFrame(32, 1'b0, '0, '0, cl, cr);
        checkOutput("after_underrun_left", cl, topBits(32'h12345678, nFull));
        checkOutput("after_underrun_right", cr, topBits(32'h9ABCDEF0, nFull));
        checkOutput("underrun_count_held", {16'd0, underrun_count}, 32'd3);

        // Fill the FIFO. A fifth pair is offered at the rising edge while the
        // FIFO is full and must be refused; one frame later a pair is pushed
        // at a rising edge while the FIFO is not full and must be accepted.
        for (int k = 0; k < 4; k++) applyStimulus(fullL[k], fullR[k]);
        checkOutput("full_ready_low", {31'd0, sample_ready}, 32'd0);
        runFrame(32, 1'b1, 32'hBAD0BAD0, 32'hBAD1BAD1, cl, cr);
        checkOutput("full_pair0_left", cl, topBits(fullL[0], nFull));
        checkOutput("full_pair0_right", cr, topBits(fullR[0], nFull));
        checkOutput("ready_after_rise", {31'd0, sample_ready}, 32'd1);
        runFrame(32, 1'b1, 32'h55555555, 32'hD5555555, cl, cr);
        checkOutput("full_pair1_left", cl, topBits(fullL[1], nFull));
        for (int k = 2; k < 4; k++) begin
            runFrame(32, 1'b0, '0, '0, cl, cr);
            checkOutput("full_pair_left", cl, topBits(fullL[k], nFull));
            checkOutput("full_pair_right", cr, topBits(fullR[k], nFull));
        end
        runFrame(32, 1'b0, '0, '0, cl, cr);
        checkOutput("pushed_at_rise_left", cl, topBits(32'h55555555, nFull));
        checkOutput("pushed_at_rise_right", cr, topBits(32'hD5555555, nFull));
        checkOutput("no_underrun_in_full", {16'd0, underrun_count}, 32'd3);

        // Short and long half-frames.
        applyStimulus(32'hCAFEBABE, 32'h13579BDF);
        runFrame(20, 1'b0, '0, '0, cl, cr);
`ifdef I2S_DELAY_EN
        checkOutput("short_left", cl, 32'h000657F5);
        checkOutput("short_right", cr, 32'h00009ABC);
`else
        checkOutput("short_left", cl, 32'h000CAFEB);
        checkOutput("short_right", cr, 32'h00013579);
`endif
        applyStimulus(32'h7FFFFFFF, 32'hFFFFFFFF);
        runFrame(40, 1'b0, '0, '0, cl, cr);
        checkOutput("long_left", cl, 32'h7FFFFFFF);
        checkOutput("long_right", cr, 32'hFFFFFFFF);

        // Reset in the middle of a left channel with two pairs still queued.
        for (int k = 0; k < 3; k++) applyStimulus(fullL[k], fullR[k]);
        AUD_DACLRCK = 1'b1;
        repeat (10) @(negedge AUD_BCLK);
        reset = 1'b1;
        @(negedge AUD_BCLK);
        checkOutput("midreset_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
        checkOutput("midreset_count", {16'd0, underrun_count}, 32'd0);
        @(negedge AUD_BCLK);
        reset = 1'b0;
        @(negedge AUD_BCLK);
        checkOutput("postreset_underrun", {31'd0, underrun}, 32'd1);
        checkOutput("postreset_count", {16'd0, underrun_count}, 32'd1);
        checkOutput("postreset_dacdat", {31'd0, AUD_DACDAT}, 32'd0);
        repeat (21) @(negedge AUD_BCLK);
        AUD_DACLRCK = 1'b0;
        repeat (32) @(negedge AUD_BCLK);
        checkOutput("postreset_final_count", {16'd0, underrun_count}, 32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
